// File: rtl/prog_loader.sv
// Boot-time program loader: takes a little-endian byte stream (16-bit word count, then
// 32-bit words), writes the words into program memory and holds the core in reset until done.
module prog_loader #(
  parameter int                    ADDR_WIDTH = 64,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    MAX_WORDS  = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERR} state_t;

  localparam logic [31:0] MAX_N = 32'(MAX_WORDS);

  state_t      state, state_n;
  logic [7:0]  len_lo;
  logic [15:0] count;
  logic [15:0] index;
  logic [1:0]  byte_cnt;

  logic        accept;
  logic [15:0] len_n;
  logic        last_word;

  logic rx_ready_n, mem_we_n, cpu_reset_n, busy_n, done_n, error_n;

  // rx_ready is itself a registered state decode, so accept never combines two live inputs.
  assign accept    = rx_valid && rx_ready;
  assign len_n     = {rx_data, len_lo};
  assign last_word = (index + 16'd1) == count;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:   if (start) state_n = LEN_LO;
      LEN_LO: if (accept) state_n = LEN_HI;
      LEN_HI: begin
        if (accept) begin
          if (len_n == 16'd0)               state_n = DONE;
          else if ({16'd0, len_n} > MAX_N)  state_n = ERR;
          else                              state_n = DATA;
        end
      end
      DATA:   if (accept && byte_cnt == 2'd3) state_n = WRITE;
      WRITE:  state_n = last_word ? DONE : DATA;
      DONE:   if (start) state_n = LEN_LO;
      ERR:    if (start) state_n = LEN_LO;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they change on the same
  // edge as the state they describe.
  always_comb begin
    rx_ready_n  = 1'b0;
    mem_we_n    = 1'b0;
    cpu_reset_n = 1'b1;
    busy_n      = 1'b0;
    done_n      = 1'b0;
    error_n     = 1'b0;
    unique case (state_n)
      LEN_LO, LEN_HI, DATA: begin
        rx_ready_n = 1'b1;
        busy_n     = 1'b1;
      end
      WRITE: begin
        mem_we_n = 1'b1;
        busy_n   = 1'b1;
      end
      DONE: begin
        cpu_reset_n = 1'b0;
        done_n      = 1'b1;
      end
      ERR:     error_n = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_ready  <= 1'b0;
      mem_we    <= 1'b0;
      cpu_reset <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      rx_ready  <= rx_ready_n;
      mem_we    <= mem_we_n;
      cpu_reset <= cpu_reset_n;
      busy      <= busy_n;
      done      <= done_n;
      error     <= error_n;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_lo    <= '0;
      count     <= '0;
      index     <= '0;
      byte_cnt  <= '0;
      mem_wdata <= '0;
      mem_addr  <= BASE_ADDR;
    end else begin
      unique case (state)
        LEN_LO: if (accept) len_lo <= rx_data;
        LEN_HI: begin
          if (accept) begin
            count    <= len_n;
            index    <= '0;
            byte_cnt <= '0;
          end
        end
        DATA: begin
          if (accept) begin
            mem_wdata[{byte_cnt, 3'b000} +: 8] <= rx_data;
            byte_cnt                           <= byte_cnt + 2'd1;
            // Address is set up as WRITE is entered so it is stable for the whole strobe.
            if (byte_cnt == 2'd3)
              mem_addr <= BASE_ADDR + ADDR_WIDTH'({index, 2'b00});
          end
        end
        WRITE:   index <= index + 16'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: stimulus queues expected memory writes, a negedge
// monitor pops and compares them whenever mem_we is seen.
module tb_prog_loader;

  localparam int                ADDR_WIDTH = 64;
  localparam logic [63:0]       BASE       = 64'h0000_0000_0000_1000;
  localparam int                MAX_WORDS  = 256;

  typedef struct {
    logic [63:0] addr;
    logic [31:0] data;
    bit          last;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  start;
  logic                  rx_valid;
  logic [7:0]            rx_data;
  logic                  rx_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic                  cpu_reset;
  logic                  busy;
  logic                  done;
  logic                  error;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   write_count = 0;
  bit   prev_we = 0;
  bit   done_pending = 0;

  prog_loader #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .BASE_ADDR (BASE),
    .MAX_WORDS (MAX_WORDS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_ready (rx_ready),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .cpu_reset(cpu_reset),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_write(input logic [63:0] addr, input logic [31:0] data, input bit last);
    exp_t e;
    e.addr = addr;
    e.data = data;
    e.last = last;
    sb.push_back(e);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Holds the byte until an edge where rx_ready was high, then optionally idles the source.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit accepted;
    int budget;
    rx_valid = 1'b1;
    rx_data  = b;
    accepted = 0;
    budget   = 0;
    while (!accepted && budget < 50) begin
      accepted = rx_ready;
      tick();
      budget++;
    end
    if (!accepted) check("byte_accept_timeout", 64'(b), 64'hffff);
    if (gap > 0) begin
      rx_valid = 1'b0;
      repeat (gap) tick();
    end
  endtask

  task automatic send_stream(input logic [7:0] bytes[$], input int gap);
    foreach (bytes[i]) send_byte(bytes[i], gap);
    rx_valid = 1'b0;
  endtask

  task automatic wait_done();
    int budget = 0;
    while (!done && budget < 100) begin
      tick();
      budget++;
    end
    check("done_reached", 64'(done), 64'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rx_ready"},  64'(rx_ready),  64'd0);
    check({tag, "_mem_we"},    64'(mem_we),    64'd0);
    check({tag, "_mem_addr"},  mem_addr,       BASE);
    check({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
    check({tag, "_cpu_reset"}, 64'(cpu_reset), 64'd1);
    check({tag, "_busy"},      64'(busy),      64'd0);
    check({tag, "_done"},      64'(done),      64'd0);
    check({tag, "_error"},     64'(error),     64'd0);
  endtask

  // Monitor: compares every write against the scoreboard and checks release timing.
  always @(negedge clk) begin
    if (reset) begin
      prev_we      = 0;
      done_pending = 0;
    end else begin
      if (done_pending) begin
        check("done_after_last_write", 64'(done), 64'd1);
        check("cpu_release_after_last_write", 64'(cpu_reset), 64'd0);
        done_pending = 0;
      end
      if (busy) check("rx_ready_only_off_in_write", 64'(rx_ready), 64'(!mem_we));
      if (mem_we) begin
        exp_t e;
        write_count++;
        check("we_one_cycle", 64'(prev_we), 64'd0);
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_write: got addr %h data %h expected no write", mem_addr, mem_wdata);
        end else begin
          e = sb.pop_front();
          check("write_addr", mem_addr, e.addr);
          check("write_data", 64'(mem_wdata), 64'(e.data));
          if (e.last) done_pending = 1;
        end
      end
      prev_we = mem_we;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    logic [7:0] img2[$];
    logic [7:0] s;
    int         wc;

    img2 = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};

    reset    = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) tick();
    check_reset_values("in_reset");
    reset = 1'b0;
    tick();
    check_reset_values("after_reset");

    // Two-word image, source streaming every cycle.
    expect_write(BASE,        32'h0010_0513, 0);
    expect_write(BASE + 64'd4, 32'h0020_0593, 1);
    pulse_start();
    check("start_busy", 64'(busy), 64'd1);
    check("start_rx_ready", 64'(rx_ready), 64'd1);
    send_stream(img2, 0);
    wait_done();
    check("img1_cpu_reset", 64'(cpu_reset), 64'd0);

    // Reload from DONE: core is re-held on the next edge; stream has 3-cycle gaps.
    expect_write(BASE,        32'h0010_0513, 0);
    expect_write(BASE + 64'd4, 32'h0020_0593, 1);
    pulse_start();
    check("reload_cpu_reset", 64'(cpu_reset), 64'd1);
    check("reload_done", 64'(done), 64'd0);
    send_stream(img2, 3);
    wait_done();

    // Zero-length image goes straight to DONE.
    wc = write_count;
    pulse_start();
    send_stream('{8'h00, 8'h00}, 0);
    check("len0_done", 64'(done), 64'd1);
    check("len0_cpu_reset", 64'(cpu_reset), 64'd0);
    check("len0_busy", 64'(busy), 64'd0);
    check("len0_no_write", 64'(write_count), 64'(wc));

    // 257 words exceeds MAX_WORDS.
    pulse_start();
    send_stream('{8'h01, 8'h01}, 0);
    check("len257_error", 64'(error), 64'd1);
    check("len257_cpu_reset", 64'(cpu_reset), 64'd1);
    check("len257_done", 64'(done), 64'd0);
    check("len257_rx_ready", 64'(rx_ready), 64'd0);
    tick();
    check("len257_no_write", 64'(write_count), 64'(wc));
    pulse_start();
    check("err_cleared", 64'(error), 64'd0);
    check("err_restart_busy", 64'(busy), 64'd1);

    // Abort partway through word 1 with an asynchronous reset.
    send_stream('{8'h02, 8'h00, 8'h13, 8'h05}, 0);
    reset = 1'b1;
    #1;
    check_reset_values("mid_load_reset");
    repeat (2) tick();
    reset = 1'b0;
    tick();
    check("abort_no_write", 64'(write_count), 64'(wc));

    expect_write(BASE,        32'h0010_0513, 0);
    expect_write(BASE + 64'd4, 32'h0020_0593, 1);
    pulse_start();
    send_stream(img2, 1);
    wait_done();

    // One-word reload with a start pulse mid-load that must be ignored.
    expect_write(BASE, 32'hdead_beef, 1);
    pulse_start();
    check("oneword_cpu_reset", 64'(cpu_reset), 64'd1);
    send_stream('{8'h01, 8'h00, 8'hef, 8'hbe}, 0);
    pulse_start();
    check("midload_start_busy", 64'(busy), 64'd1);
    check("midload_start_done", 64'(done), 64'd0);
    s = 8'had;
    send_byte(s, 0);
    s = 8'hde;
    send_byte(s, 0);
    rx_valid = 1'b0;
    wait_done();

    repeat (5) tick();
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Boot-time instruction loader for the single-cycle RISC-V core. It is the write side of the program memory, which the core only ever reads. It accepts a byte stream (16-bit little-endian word count, then little-endian 32-bit instruction words) and writes each assembled word into program memory at consecutive word addresses. It holds the core in reset until the image is fully written.

## Interface

Parameters:
- ADDR_WIDTH, 64, width of mem_addr; matches the PC width.
- BASE_ADDR, 0, byte address of the first written word.
- MAX_WORDS, 256, largest accepted word count; must match program memory depth.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock (post clock divider, same clock as PC and registers).
- reset  in  1  asynchronous, active-high.
- start  in  1  single-cycle request to begin a load; honoured only in IDLE, DONE or ERR.
- rx_valid  in  1  byte available on rx_data.
- rx_data  in  8  stream byte.
- rx_ready  out  1  loader can take a byte; a byte transfers on a cycle with rx_valid && rx_ready.
- mem_we  out  1  program-memory write strobe, one cycle per word.
- mem_addr  out  ADDR_WIDTH  byte address of the word being written.
- mem_wdata  out  32  instruction word being written.
- cpu_reset  out  1  drives the core's reset; high while not DONE.
- busy  out  1  load in progress.
- done  out  1  image loaded, core released.
- error  out  1  word count was greater than MAX_WORDS.

## Operation

- States: IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERR.
- Reset values: state IDLE, rx_ready 0, mem_we 0, mem_addr BASE_ADDR, mem_wdata 0, cpu_reset 1, busy 0, done 0, error 0, internal count, index and byte counters 0.
- IDLE:
  - start moves to LEN_LO.
  - cpu_reset=1.
- LEN_LO and LEN_HI:
  - rx_ready=1.
  - Accepted bytes form N = {hi, lo}.
  - After the hi byte:
    - N == 0 → DONE.
    - N > MAX_WORDS → ERR.
    - otherwise → DATA with index=0.
- DATA:
  - rx_ready=1.
  - The k-th accepted byte (k = 0..3) goes into mem_wdata[8k+7:8k].
  - On the 4th byte → WRITE.
- WRITE (one cycle):
  - rx_ready=0, mem_we=1.
  - mem_addr = BASE_ADDR + 4*index, computed modulo 2^ADDR_WIDTH.
  - Next cycle: index+1; → DONE if index+1 == N, else → DATA.
- busy=1 in LEN_LO, LEN_HI, DATA and WRITE.
- DONE:
  - cpu_reset=0, done=1, rx_ready=0.
  - start → LEN_LO: done and cpu_reset change on the next edge, i.e. the core is re-held for the reload.
- ERR:
  - error=1, cpu_reset=1, rx_ready=0.
  - start → LEN_LO and clears error.
- start while busy is ignored. Bytes offered in IDLE, WRITE, DONE or ERR are not accepted (rx_ready=0).

## Timing

- All outputs are registered. The only asynchronous path is reset.
- rx_ready is a state decode: it may depend on state only, never on rx_valid.
- A byte is captured on the rising edge where rx_valid && rx_ready.
- mem_we rises on the edge after the 4th data byte is captured and stays high exactly one cycle. mem_addr and mem_wdata are stable throughout that cycle.
- Throughput is at most one word per 5 cycles, with the source streaming every cycle.
- The transition to DONE happens on the edge ending the last WRITE cycle. cpu_reset falls on that same edge.
- Reset mid-load: returns to the reset values immediately and discards any partial word. Words already written stay in memory. cpu_reset is 1 throughout.
- rx_valid gaps (idle cycles) anywhere in the stream only stall the loader. There is no timeout.

## Test plan

- Reset, then start, then bytes 02 00 13 05 10 00 93 05 20 00 → mem_we pulses twice: 0x00100513 @ BASE_ADDR, then 0x00200593 @ BASE_ADDR+4. done=1 and cpu_reset=0 on the edge after the 2nd write.
- Same stream with rx_valid low for 3 cycles between every byte → identical writes. rx_ready=0 only during WRITE. No byte is lost or duplicated.
- Length 00 00 → DONE directly after 2 bytes, no mem_we. Length 01 01 (257, with MAX_WORDS=256) → error=1, cpu_reset=1, no mem_we. A following start clears error.
- Assert reset after 2 of 4 bytes of word 1 → all outputs at reset values. A fresh start/stream loads correctly from BASE_ADDR.
- In DONE, pulse start and load a 1-word image → cpu_reset returns to 1 the next cycle. A single write at BASE_ADDR, then done=1. A start pulsed mid-load is ignored.
